axi4_split_custom: RTL and testbench

//  1:2 AXI4-Stream packet router; the opposite end of the 2:1 switch.
//  One slave input (s0) is steered whole-packet to master m0 or m1, chosen by a tuser bit on the first beat.

---
 rtl/axi4_split_custom_if.sv | 15 +
 rtl/axi4_split_custom.sv | 77 +++++++
 tb/tb_axi4_split_custom.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_split_custom_if.sv
// axi4_split_custom_if: AXI4-Stream channel bundle (data, user, keep, last, valid/ready)
interface axi4_split_custom_if #(
  parameter int TDATA_L = 512,
  parameter int TUSER_L = 81,
  parameter int TKEEP_L = 16
);
  logic [TDATA_L-1:0] tdata;
  logic [TUSER_L-1:0] tuser;
  logic [TKEEP_L-1:0] tkeep;
  logic tlast;
  logic tvalid;
  logic tready;
  modport master (output tdata, tuser, tkeep, tlast, tvalid, input tready);
  modport slave (input tdata, tuser, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axi4_split_custom.sv
// axi4_split_custom: 1:2 AXI4-Stream packet router, whole packets steered by a tuser bit at SOP
module axi4_split_custom #(
  parameter int TDATA_L  = 512,
  parameter int TUSER_L  = 81,
  parameter int TKEEP_L  = 16,
  parameter int DEST_BIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           m_dest_block,
  axi4_split_custom_if.slave   s0,
  axi4_split_custom_if.master  m0,
  axi4_split_custom_if.master  m1,
  output logic [CNT_W-1:0]     pkt_cnt0,
  output logic [CNT_W-1:0]     pkt_cnt1
);
  typedef enum logic {SOP, BODY} state_t;
  state_t state, state_n;
  logic dest_r, dest_n, dest_c, dest, acc;
  logic [1:0] free;
  assign free = {!m1.tvalid || m1.tready, !m0.tvalid || m0.tready};
  assign dest_c = s0.tuser[DEST_BIT];
  assign dest = (state == SOP) ? dest_c : dest_r;
  // m_dest_block only gates packet starts; a packet in flight always completes
  assign s0.tready = (state == SOP) ? free[dest_c] && !m_dest_block[dest_c] : free[dest_r];
  assign acc = s0.tvalid && s0.tready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= SOP;
      dest_r <= 1'b0;
    end else begin
      state  <= state_n;
      dest_r <= dest_n;
    end
  always_comb begin
    state_n = acc ? (s0.tlast ? SOP : BODY) : state;
    dest_n = (acc && state == SOP) ? dest_c : dest_r;
  end
  // Loading wins over draining so a slice can take a new beat in the cycle it empties
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m0.tvalid <= 1'b0;
      m0.tdata  <= '0;
      m0.tuser  <= '0;
      m0.tkeep  <= '0;
      m0.tlast  <= 1'b0;
      pkt_cnt0  <= '0;
    end else begin
      if (acc && !dest) begin
        m0.tvalid <= 1'b1;
        m0.tdata  <= s0.tdata;
        m0.tuser  <= s0.tuser;
        m0.tkeep  <= s0.tkeep;
        m0.tlast  <= s0.tlast;
      end else if (m0.tready) m0.tvalid <= 1'b0;
      pkt_cnt0 <= pkt_cnt0 + CNT_W'(m0.tvalid && m0.tready && m0.tlast);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m1.tvalid <= 1'b0;
      m1.tdata  <= '0;
      m1.tuser  <= '0;
      m1.tkeep  <= '0;
      m1.tlast  <= 1'b0;
      pkt_cnt1  <= '0;
    end else begin
      if (acc && dest) begin
        m1.tvalid <= 1'b1;
        m1.tdata  <= s0.tdata;
        m1.tuser  <= s0.tuser;
        m1.tkeep  <= s0.tkeep;
        m1.tlast  <= s0.tlast;
      end else if (m1.tready) m1.tvalid <= 1'b0;
      pkt_cnt1 <= pkt_cnt1 + CNT_W'(m1.tvalid && m1.tready && m1.tlast);
    end
endmodule

// File: tb/tb_axi4_split_custom.sv
// tb_axi4_split_custom: scoreboard bench for the 1:2 packet router
module tb_axi4_split_custom;
  localparam int DL = 512, UL = 81, KL = 16, CW = 2;
  typedef struct packed {logic [DL-1:0] d; logic [UL-1:0] u; logic [KL-1:0] k; logic l;} beat_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] m_dest_block = 2'b00;
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;
  axi4_split_custom_if #(.TDATA_L(DL), .TUSER_L(UL), .TKEEP_L(KL)) s0 (), m0 (), m1 ();
  axi4_split_custom #(.TDATA_L(DL), .TUSER_L(UL), .TKEEP_L(KL), .DEST_BIT(0), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .m_dest_block(m_dest_block),
    .s0(s0), .m0(m0), .m1(m1), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1));
  beat_t exp0[$], exp1[$];
  int pass = 0, total = 0, cyc = 0, nout = 0, last_hs = 0, cnt0 = 0, cnt1 = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Outputs are observed mid-cycle; a handshake seen here completes on the next rising edge
  always @(negedge clk) begin : mon
    beat_t g, e;
    if (rst_n && m0.tvalid && m0.tready) begin
      g = {m0.tdata, m0.tuser, m0.tkeep, m0.tlast};
      total++;
      if (exp0.size() == 0) $display("FAIL m0_unexpected got %h exp none", g);
      else begin
        e = exp0.pop_front();
        if (g !== e) $display("FAIL m0_beat got %h exp %h", g, e); else pass++;
      end
      nout++;
      last_hs = cyc;
    end
    if (rst_n && m1.tvalid && m1.tready) begin
      g = {m1.tdata, m1.tuser, m1.tkeep, m1.tlast};
      total++;
      if (exp1.size() == 0) $display("FAIL m1_unexpected got %h exp none", g);
      else begin
        e = exp1.pop_front();
        if (g !== e) $display("FAIL m1_beat got %h exp %h", g, e); else pass++;
      end
      nout++;
      last_hs = cyc;
    end
  end
  function automatic beat_t mk(bit dest, bit last);
    beat_t b;
    for (int i = 0; i < DL / 32; i++) b.d[i*32 +: 32] = $urandom;
    b.u = UL'({$urandom, $urandom, $urandom});
    b.u[0] = dest;
    b.k = KL'($urandom);
    b.l = last;
    return b;
  endfunction
  task automatic drive(beat_t b);
    {s0.tdata, s0.tuser, s0.tkeep, s0.tlast} = b;
    s0.tvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s0.tready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    total++;
    $display("FAIL drive_timeout tready got 0 exp 1");
    s0.tvalid = 1'b0;
  endtask
  task automatic send_pkt(bit dest, int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b = mk(i == 0 ? dest : ~dest, i == n - 1);
      if (dest) exp1.push_back(b); else exp0.push_back(b);
      if (i == n - 1) begin
        if (dest) cnt1++; else cnt0++;
      end
      drive(b);
    end
  endtask
  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (exp0.size() == 0 && exp1.size() == 0) return;
      @(negedge clk);
      #1;
    end
    total++;
    $display("FAIL drain_timeout pending m0=%0d m1=%0d exp 0", exp0.size(), exp1.size());
  endtask
  task automatic check_cnts(string tag);
    @(posedge clk);
    #1;
    total++;
    if (pkt_cnt0 !== CW'(cnt0)) $display("FAIL %s_cnt0 got %0d exp %0d", tag, pkt_cnt0, CW'(cnt0)); else pass++;
    total++;
    if (pkt_cnt1 !== CW'(cnt1)) $display("FAIL %s_cnt1 got %0d exp %0d", tag, pkt_cnt1, CW'(cnt1)); else pass++;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    s0.tvalid = 1'b0; s0.tdata = '0; s0.tuser = '0; s0.tkeep = '0; s0.tlast = 1'b0;
    m0.tready = 1'b1; m1.tready = 1'b1; m_dest_block = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({m0.tvalid, m1.tvalid} !== 2'b00) $display("FAIL rst_valid got %b exp 00", {m0.tvalid, m1.tvalid}); else pass++;
    total++;
    if ({pkt_cnt0, pkt_cnt1} !== '0) $display("FAIL rst_cnt got %h exp 0", {pkt_cnt0, pkt_cnt1}); else pass++;
    total++;
    if (m0.tdata !== '0 || m1.tuser !== '0 || m0.tlast !== 1'b0 || m1.tkeep !== '0)
      $display("FAIL rst_data got nonzero exp 0"); else pass++;
    s0.tuser[0] = 1'b1; m_dest_block = 2'b10;
    #1;
    total++;
    if (s0.tready !== 1'b0) $display("FAIL rst_ready_blocked got %b exp 0", s0.tready); else pass++;
    m_dest_block = 2'b01;
    #1;
    total++;
    if (s0.tready !== 1'b1) $display("FAIL rst_ready_free got %b exp 1", s0.tready); else pass++;
    m_dest_block = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_single();
    beat_t b;
    b = mk(1'b0, 1'b1);
    exp0.push_back(b);
    cnt0++;
    drive(b);
    s0.tvalid = 1'b0;
    total++;
    if (m0.tvalid !== 1'b1 || m0.tdata !== b.d) $display("FAIL single_latency got v=%b exp v=1 with data", m0.tvalid); else pass++;
    total++;
    if (m1.tvalid !== 1'b0) $display("FAIL single_m1_idle got %b exp 0", m1.tvalid); else pass++;
    wait_drain();
    check_cnts("single");
  endtask
  task automatic test_multi();
    send_pkt(1'b1, 3);
    s0.tvalid = 1'b0;
    wait_drain();
    check_cnts("multi");
  endtask
  task automatic test_backpressure();
    m0.tready = 1'b0;
    fork
      begin
        send_pkt(1'b0, 3);
        send_pkt(1'b1, 1);
        s0.tvalid = 1'b0;
      end
      begin
        repeat (6) @(negedge clk);
        total++;
        if (m0.tvalid !== 1'b1 || m0.tdata !== exp0[0].d) $display("FAIL bp_hold got v=%b exp v=1 with beat0", m0.tvalid); else pass++;
        total++;
        if (s0.tready !== 1'b0) $display("FAIL bp_ready got %b exp 0", s0.tready); else pass++;
        total++;
        if (m1.tvalid !== 1'b0) $display("FAIL bp_m1_stall got %b exp 0", m1.tvalid); else pass++;
        @(posedge clk);
        #1;
        m0.tready = 1'b1;
      end
    join
    wait_drain();
    check_cnts("bp");
  endtask
  task automatic test_block();
    m_dest_block = 2'b10;
    fork
      send_pkt(1'b1, 1);
      begin
        repeat (4) @(negedge clk);
        total++;
        if (s0.tready !== 1'b0) $display("FAIL block_ready got %b exp 0", s0.tready); else pass++;
        total++;
        if (m1.tvalid !== 1'b0) $display("FAIL block_m1 got %b exp 0", m1.tvalid); else pass++;
        @(posedge clk);
        #1;
        m_dest_block = 2'b00;
      end
    join
    s0.tvalid = 1'b0;
    fork
      send_pkt(1'b0, 3);
      begin
        @(posedge clk);
        #2;
        m_dest_block = 2'b01;
      end
    join
    s0.tvalid = 1'b0;
    wait_drain();
    check_cnts("block");
    m_dest_block = 2'b00;
  endtask
  task automatic test_back_to_back();
    int t0, n0;
    @(posedge clk);
    #1;
    t0 = cyc;
    n0 = nout;
    for (int i = 0; i < 20; i++) send_pkt(i[0], 1);
    s0.tvalid = 1'b0;
    wait_drain();
    total++;
    if (nout - n0 !== 20) $display("FAIL b2b_beats got %0d exp 20", nout - n0); else pass++;
    total++;
    if (last_hs - t0 + 1 !== 21) $display("FAIL b2b_cycles got %0d exp 21", last_hs - t0 + 1); else pass++;
    check_cnts("b2b");
  endtask
  task automatic test_reset_mid();
    m1.tready = 1'b0;
    drive(mk(1'b1, 1'b0));
    rst_n = 1'b0;
    #1;
    total++;
    if (m1.tvalid !== 1'b0 || m1.tdata !== '0) $display("FAIL rstmid_m1 got v=%b exp 0", m1.tvalid); else pass++;
    total++;
    if ({pkt_cnt0, pkt_cnt1} !== '0) $display("FAIL rstmid_cnt got %h exp 0", {pkt_cnt0, pkt_cnt1}); else pass++;
    s0.tuser[0] = 1'b0;
    m_dest_block = 2'b01;
    #1;
    total++;
    if (s0.tready !== 1'b0) $display("FAIL rstmid_sop got %b exp 0", s0.tready); else pass++;
    m_dest_block = 2'b00;
    s0.tvalid = 1'b0;
    m1.tready = 1'b1;
    cnt0 = 0;
    cnt1 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_wrap();
    for (int i = 0; i < 5; i++) send_pkt(1'b0, 1);
    s0.tvalid = 1'b0;
    wait_drain();
    @(posedge clk);
    #1;
    total++;
    if (pkt_cnt0 !== 2'd1) $display("FAIL wrap_cnt0 got %0d exp 1", pkt_cnt0); else pass++;
    total++;
    if (pkt_cnt1 !== 2'd0) $display("FAIL wrap_cnt1 got %0d exp 0", pkt_cnt1); else pass++;
  endtask
  initial begin
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_block();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
